paint_brush_ctrl: RTL and testbench

//   Parametrised cursor/brush engine for the paint canvas. Replaces the fixed single-pixel cursor

---
 rtl/paint_brush_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_paint_brush_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/paint_brush_ctrl.sv
// paint_brush_ctrl: cursor/brush engine for the paint canvas. It moves the cursor on
// a built-in tick and stamps an SxS brush square as a plot stream for the VGA adapter.
// Ports:
//     clk, reset (sync, active-high)
//     up/down/left/right: move requests
//     pen_down: stamp the brush on each move tick
//     erase: stamp colour 0
//     clr_in: brush colour
//     brush_size: brush side minus 1
//     x/y/colour/plot: registered pixel write to the VGA adapter
//     busy: high while the brush is being stamped
module paint_brush_ctrl #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int CLR_W    = 3,
    parameter int X_MIN    = 10,
    parameter int X_MAX    = 150,
    parameter int Y_MIN    = 10,
    parameter int Y_MAX    = 110,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 60,
    parameter int TICK_DIV = 781250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             pen_down,
    input  logic             erase,
    input  logic [CLR_W-1:0] clr_in,
    input  logic [1:0]       brush_size,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [CLR_W-1:0] colour,
    output logic             plot,
    output logic             busy
);

    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0]   XMIN_V     = X_W'(X_MIN);
    localparam logic [X_W-1:0]   XMAX_V     = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   YMIN_V     = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]   YMAX_V     = Y_W'(Y_MAX);
    localparam logic [X_W:0]     XMAX_E     = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]     YMAX_E     = (Y_W+1)'(Y_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        PAINT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    logic [X_W-1:0]   cur_x_q, cur_x_d, org_x_q, org_x_d, mv_x, x_d;
    logic [Y_W-1:0]   cur_y_q, cur_y_d, org_y_q, org_y_d, mv_y, y_d;
    logic [1:0]       s_q, s_d, dx_q, dx_d, dy_q, dy_d;
    logic [1:0]       ndx, ndy;
    logic [CLR_W-1:0] colour_d;
    logic             plot_d;
    logic             pend_q, pend_d;
    logic             last_px;
    logic [X_W:0]     sum_x;
    logic [Y_W:0]     sum_y;

    assign tick = (cnt_q == '0);
    assign busy = (state_q == PAINT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_RELOAD;
        end else if (tick) begin
            cnt_q <= CNT_RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Saturating per-axis cursor step; opposing requests cancel.
    always_comb begin
        mv_x = cur_x_q;
        mv_y = cur_y_q;
        if (left && !right && cur_x_q > XMIN_V) begin
            mv_x = cur_x_q - 1'b1;
        end else if (right && !left && cur_x_q < XMAX_V) begin
            mv_x = cur_x_q + 1'b1;
        end
        if (up && !down && cur_y_q > YMIN_V) begin
            mv_y = cur_y_q - 1'b1;
        end else if (down && !up && cur_y_q < YMAX_V) begin
            mv_y = cur_y_q + 1'b1;
        end
    end

    // Raster walk over the brush, dx fastest; s_q holds side-1.
    always_comb begin
        last_px = (dx_q == s_q) && (dy_q == s_q);
        if (dx_q == s_q) begin
            ndx = 2'd0;
            ndy = dy_q + 2'd1;
        end else begin
            ndx = dx_q + 2'd1;
            ndy = dy_q;
        end
        // One extra bit so pixels past the canvas edge clip instead of wrapping.
        sum_x = {1'b0, org_x_q} + {{(X_W-1){1'b0}}, ndx};
        sum_y = {1'b0, org_y_q} + {{(Y_W-1){1'b0}}, ndy};
    end

    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        org_x_d  = org_x_q;
        org_y_d  = org_y_q;
        s_d      = s_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        plot_d   = 1'b0;
        pend_d   = pend_q;
        unique case (state_q)
            IDLE: begin
                if (tick || pend_q) begin
                    pend_d  = 1'b0;
                    cur_x_d = mv_x;
                    cur_y_d = mv_y;
                    x_d     = mv_x;
                    y_d     = mv_y;
                    if (pen_down) begin
                        // First brush pixel (0,0) goes out on the entry edge.
                        state_d  = PAINT;
                        s_d      = brush_size;
                        colour_d = erase ? '0 : clr_in;
                        org_x_d  = mv_x;
                        org_y_d  = mv_y;
                        dx_d     = 2'd0;
                        dy_d     = 2'd0;
                        plot_d   = (mv_x <= XMAX_V) && (mv_y <= YMAX_V);
                    end
                end
            end
            PAINT: begin
                // A tick that lands mid-stamp is remembered once.
                if (tick) begin
                    pend_d = 1'b1;
                end
                if (last_px) begin
                    state_d = IDLE;
                end else begin
                    dx_d   = ndx;
                    dy_d   = ndy;
                    x_d    = sum_x[X_W-1:0];
                    y_d    = sum_y[Y_W-1:0];
                    plot_d = (sum_x <= XMAX_E) && (sum_y <= YMAX_E);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_x_q <= X_W'(X_INIT);
            cur_y_q <= Y_W'(Y_INIT);
            org_x_q <= X_W'(X_INIT);
            org_y_q <= Y_W'(Y_INIT);
            s_q     <= 2'd0;
            dx_q    <= 2'd0;
            dy_q    <= 2'd0;
            x       <= X_W'(X_INIT);
            y       <= Y_W'(Y_INIT);
            colour  <= '0;
            plot    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            org_x_q <= org_x_d;
            org_y_q <= org_y_d;
            s_q     <= s_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            x       <= x_d;
            y       <= y_d;
            colour  <= colour_d;
            plot    <= plot_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_paint_brush_ctrl.sv
// tb_paint_brush_ctrl: directed stimulus with a pixel scoreboard for paint_brush_ctrl.
// Expected plot pixels are queued by the stimulus and checked by a monitor on each plot.
module tb_paint_brush_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       up, down, left, right;
    logic       pen_down, erase;
    logic [2:0] clr_in;
    logic [1:0] brush_size;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    px_t q[$];

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    paint_brush_ctrl #(
        .TICK_DIV(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .pen_down  (pen_down),
        .erase     (erase),
        .clr_in    (clr_in),
        .brush_size(brush_size),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pixel monitor: every plot strobe must match the next queued pixel.
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL stray_plot got (%0d,%0d) c=%0d, required no plot",
                         x, y, colour);
            end else begin
                px_t e;
                e = q.pop_front();
                if (x !== e.x || y !== e.y || colour !== e.c) begin
                    failures++;
                    $display("FAIL pixel got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                             x, y, colour, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0d, required %0d", n, act, exp);
        end
    endtask

    task automatic push(input int px, input int py, input int pc);
        px_t e;
        e.x = 8'(px);
        e.y = 7'(py);
        e.c = 3'(pc);
        q.push_back(e);
    endtask

    // Waits until the sample point just after rising edge number e.
    task automatic to_edge(input int e);
        while (edge_n < e) begin
            @(negedge clk);
            edge_n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        up = 0; down = 0; left = 0; right = 0;
        pen_down = 0; erase = 0; clr_in = 0; brush_size = 0;
        do_reset();

        chk("rst_x", int'(x), 80);
        chk("rst_y", int'(y), 60);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);

        to_edge(40);
        chk("idle_x", int'(x), 80);
        chk("idle_y", int'(y), 60);
        chk("idle_busy", int'(busy), 0);

        // 2x2 stamp at (80,60), colour 5, on tick edge 48.
        pen_down = 1; brush_size = 1; clr_in = 5;
        push(80, 60, 5); push(81, 60, 5); push(80, 61, 5); push(81, 61, 5);
        to_edge(48);
        chk("paint_busy_first", int'(busy), 1);
        pen_down = 0;
        to_edge(51);
        chk("paint_busy_last", int'(busy), 1);
        to_edge(52);
        chk("paint_busy_done", int'(busy), 0);
        chk("paint_plot_done", int'(plot), 0);

        // Same stamp with erase: colour 0.
        pen_down = 1; erase = 1;
        push(80, 60, 0); push(81, 60, 0); push(80, 61, 0); push(81, 61, 0);
        to_edge(64);
        chk("erase_busy", int'(busy), 1);
        pen_down = 0; erase = 0;
        to_edge(68);
        chk("erase_busy_done", int'(busy), 0);
        chk("erase_colour_hold", int'(colour), 0);

        // Right for three ticks, pen up; up+down cancels.
        do_reset();
        right = 1;
        to_edge(16);
        chk("mv_x1", int'(x), 81);
        to_edge(32);
        chk("mv_x2", int'(x), 82);
        up = 1; down = 1;
        to_edge(48);
        chk("mv_x3", int'(x), 83);
        chk("mv_y_cancel", int'(y), 60);

        // Diagonal right+down to the bottom-right corner, then saturate.
        up = 0;
        to_edge(64);
        chk("diag_x", int'(x), 84);
        chk("diag_y", int'(y), 61);
        to_edge(1104);
        chk("sat_x149", int'(x), 149);
        chk("sat_y110", int'(y), 110);
        to_edge(1120);
        chk("sat_x150", int'(x), 150);
        to_edge(1168);
        chk("sat_hold_x", int'(x), 150);
        chk("sat_hold_y", int'(y), 110);
        up = 1;
        to_edge(1184);
        chk("corner_x", int'(x), 150);
        chk("corner_y", int'(y), 110);

        // 3x3 brush at the corner: only the origin pixel is on canvas.
        up = 0; down = 0; right = 0;
        pen_down = 1; brush_size = 2; clr_in = 3;
        push(150, 110, 3);
        to_edge(1200);
        chk("clip_busy_first", int'(busy), 1);
        pen_down = 0;
        to_edge(1208);
        chk("clip_busy_last", int'(busy), 1);
        to_edge(1209);
        chk("clip_busy_done", int'(busy), 0);

        // left+right cancels while up moves.
        left = 1; right = 1; up = 1;
        to_edge(1216);
        chk("lr_cancel_x", int'(x), 150);
        chk("up_y", int'(y), 109);
        left = 0; right = 0; up = 0;

        // 4x4 stamp; the tick during its last cycle is held and serviced next.
        do_reset();
        pen_down = 1; brush_size = 3; clr_in = 6;
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                push(80 + dx, 60 + dy, 6);
            end
        end
        to_edge(16);
        pen_down = 0;
        to_edge(31);
        chk("big_busy_last", int'(busy), 1);
        right = 1;
        to_edge(32);
        chk("big_busy_done", int'(busy), 0);
        chk("big_last_x", int'(x), 83);
        chk("big_last_y", int'(y), 63);
        to_edge(33);
        chk("pend_x", int'(x), 81);
        chk("pend_y", int'(y), 60);
        right = 0;

        // Reset during the second PAINT cycle.
        do_reset();
        pen_down = 1; brush_size = 1; clr_in = 2;
        push(80, 60, 2); push(81, 60, 2);
        to_edge(17);
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        pen_down = 0;
        @(negedge clk);
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_x", int'(x), 80);
        chk("mid_rst_y", int'(y), 60);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
